successive_clap_sequencer: RTL and testbench

Groups accepted clap events into bursts separated by silence, measured in energy frames, and emits one burst length per burst on a valid/ready stream. It sits between the clap detector and the light-control logic. It observes the energy-frame handshake as its time base. Compared with the earlier successive-claps counter, it adds a restartable inactivity window, a per-clap refractory period, a saturating count, optional zero-reports, and a drop indication.

---
 rtl/clap_pkg.sv | 22 ++
 rtl/clap_window_timer.sv | 45 ++++
 rtl/successive_clap_sequencer.sv | 112 +++++++++++
 tb/tb_successive_clap_sequencer.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/clap_pkg.sv
// Shared definitions for the clap detection path: sequencer state encoding,
// default frame constants and the counter width helper.
package clap_pkg;

  // Defaults kept in one place so the detector and the sequencer agree.
  localparam int DEF_WINDOW_FRAMES  = 32;
  localparam int DEF_REFRACT_FRAMES = 2;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  // Bits needed to hold values 0..value-1; never less than one bit.
  function automatic int clogb2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/clap_window_timer.sv
// Inactivity window and refractory counters, both advanced by energy-frame ticks.
// A restart (counted clap) overrides a simultaneous tick or clear.
module clap_window_timer
  import clap_pkg::*;
#(
  parameter int WINDOW_FRAMES  = DEF_WINDOW_FRAMES,
  parameter int REFRACT_FRAMES = DEF_REFRACT_FRAMES
) (
  input  logic clock,
  input  logic reset,
  input  logic tick,
  input  logic restart,
  input  logic clear,
  output logic window_expired,
  output logic refract_active
);

  localparam int WW = clogb2(WINDOW_FRAMES);
  localparam int RW = clogb2(REFRACT_FRAMES + 1);
  localparam logic [WW-1:0] WIN_LAST     = WW'(WINDOW_FRAMES - 1);
  localparam logic [RW-1:0] REFRACT_LOAD = RW'(REFRACT_FRAMES);

  logic [WW-1:0] window;
  logic [RW-1:0] refract;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      window  <= '0;
      refract <= '0;
    end else if (restart) begin
      window  <= '0;
      refract <= REFRACT_LOAD;
    end else if (clear) begin
      window  <= '0;
      refract <= '0;
    end else if (tick) begin
      window <= (window == WIN_LAST) ? '0 : window + WW'(1);
      if (refract != '0) refract <= refract - RW'(1);
    end
  end

  assign window_expired = (window == WIN_LAST);
  assign refract_active = (refract != '0);

endmodule

// File: rtl/successive_clap_sequencer.sv
// Groups accepted claps into bursts closed by a silent frame window and
// reports each burst length through a one-entry valid/ready output slot.
module successive_clap_sequencer
  import clap_pkg::*;
#(
  parameter int SUC_CLAPS_WIDTH = 8,
  parameter int WINDOW_FRAMES   = DEF_WINDOW_FRAMES,
  parameter int REFRACT_FRAMES  = DEF_REFRACT_FRAMES,
  parameter bit EMIT_ZERO       = 1'b0
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       clap_valid,
  output logic                       clap_ready,
  input  logic                       energy_valid,
  input  logic                       energy_ready,
  output logic [SUC_CLAPS_WIDTH-1:0] suc_claps_data,
  output logic                       suc_claps_valid,
  input  logic                       suc_claps_ready,
  output logic                       drop_pulse,
  output logic                       busy
);

  state_t                     state_q, state_d;
  logic [SUC_CLAPS_WIDTH-1:0] count_q, count_d;
  logic [SUC_CLAPS_WIDTH-1:0] result;
  logic tick, accept, counted, produce, slot_load;
  logic timer_tick, timer_clear, window_expired, refract_active;

  assign tick    = energy_valid & energy_ready;
  assign accept  = clap_valid & clap_ready;
  assign counted = accept & ~refract_active;

  clap_window_timer #(
    .WINDOW_FRAMES (WINDOW_FRAMES),
    .REFRACT_FRAMES(REFRACT_FRAMES)
  ) u_timer (
    .clock         (clock),
    .reset         (reset),
    .tick          (timer_tick),
    .restart       (counted),
    .clear         (timer_clear),
    .window_expired(window_expired),
    .refract_active(refract_active)
  );

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    produce     = 1'b0;
    result      = '0;
    timer_tick  = 1'b0;
    timer_clear = 1'b0;
    case (state_q)
      IDLE: begin
        if (counted) begin
          state_d = ACTIVE;
          count_d = SUC_CLAPS_WIDTH'(1);
        end else if (EMIT_ZERO && tick) begin
          timer_tick = 1'b1;
          if (window_expired) begin
            produce     = 1'b1;
            timer_clear = 1'b1;
          end
        end
      end
      ACTIVE: begin
        // A counted clap keeps the burst open even on the closing tick.
        if (counted) begin
          count_d = (count_q == '1) ? count_q : count_q + SUC_CLAPS_WIDTH'(1);
        end else if (tick) begin
          timer_tick = 1'b1;
          if (window_expired) begin
            produce     = 1'b1;
            result      = count_q;
            state_d     = IDLE;
            count_d     = '0;
            timer_clear = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign slot_load = produce & (~suc_claps_valid | suc_claps_ready);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q         <= IDLE;
      count_q         <= '0;
      clap_ready      <= 1'b0;
      suc_claps_valid <= 1'b0;
      suc_claps_data  <= '0;
      drop_pulse      <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      clap_ready <= 1'b1;
      drop_pulse <= produce & ~slot_load;
      if (slot_load) begin
        suc_claps_valid <= 1'b1;
        suc_claps_data  <= result;
      end else if (suc_claps_ready) begin
        suc_claps_valid <= 1'b0;
      end
    end
  end

  assign busy = (state_q == ACTIVE);

endmodule

// File: tb/tb_successive_clap_sequencer.sv
// Directed bench: WIDTH=3, WINDOW=4, REFRACT=1; a second instance with EMIT_ZERO=1
// shares the inputs and is checked only in the zero-report and reset steps.
module tb_successive_clap_sequencer;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       clap_valid = 1'b0;
  logic       energy_valid = 1'b0;
  logic       energy_ready = 1'b0;
  logic       suc_claps_ready = 1'b1;
  logic       ready_z = 1'b1;

  logic       clap_ready, suc_claps_valid, drop_pulse, busy;
  logic [2:0] suc_claps_data;
  logic       clap_ready_z, valid_z, drop_z, busy_z;
  logic [2:0] data_z;

  int tests = 0;
  int fails = 0;

  always #5 clock = ~clock;

  successive_clap_sequencer #(
    .SUC_CLAPS_WIDTH(3), .WINDOW_FRAMES(4), .REFRACT_FRAMES(1), .EMIT_ZERO(1'b0)
  ) u_dut (
    .clock(clock), .reset(reset),
    .clap_valid(clap_valid), .clap_ready(clap_ready),
    .energy_valid(energy_valid), .energy_ready(energy_ready),
    .suc_claps_data(suc_claps_data), .suc_claps_valid(suc_claps_valid),
    .suc_claps_ready(suc_claps_ready), .drop_pulse(drop_pulse), .busy(busy)
  );

  successive_clap_sequencer #(
    .SUC_CLAPS_WIDTH(3), .WINDOW_FRAMES(4), .REFRACT_FRAMES(1), .EMIT_ZERO(1'b1)
  ) u_dut_z (
    .clock(clock), .reset(reset),
    .clap_valid(clap_valid), .clap_ready(clap_ready_z),
    .energy_valid(energy_valid), .energy_ready(energy_ready),
    .suc_claps_data(data_z), .suc_claps_valid(valid_z),
    .suc_claps_ready(ready_z), .drop_pulse(drop_z), .busy(busy_z)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock with the given inputs; returns 1 time unit after the edge.
  task automatic step3(input logic c, input logic ev, input logic er);
    clap_valid   = c;
    energy_valid = ev;
    energy_ready = er;
    @(posedge clock);
    #1;
    clap_valid   = 1'b0;
    energy_valid = 1'b0;
    energy_ready = 1'b0;
  endtask

  task automatic step(input logic c, input logic t);
    step3(c, t, t);
  endtask

  // A frame: optional clap cycle, then the tick cycle.
  task automatic frame(input logic c);
    if (c) step(1'b1, 1'b0);
    step(1'b0, 1'b1);
  endtask

  initial begin
    // Reset values
    #3;
    check("rst_valid", suc_claps_valid, 0);
    check("rst_data", suc_claps_data, 0);
    check("rst_drop", drop_pulse, 0);
    check("rst_busy", busy, 0);
    check("rst_clap_ready", clap_ready, 0);
    @(posedge clock);
    @(posedge clock);
    #1;
    reset = 1'b0;
    check("clap_ready_low_before_edge", clap_ready, 0);
    step(1'b0, 1'b0);
    check("clap_ready_rise", clap_ready, 1);

    // Basic burst: claps at frames 0, 2, 5; close on frame 8
    for (int f = 0; f <= 7; f++) begin
      frame(f == 0 || f == 2 || f == 5);
      if (f == 6) begin
        step3(1'b0, 1'b1, 1'b0);
        step3(1'b0, 1'b0, 1'b1);
      end
      check("basic_no_result", suc_claps_valid, 0);
      check("basic_busy", busy, 1);
    end
    frame(1'b0);
    check("basic_valid", suc_claps_valid, 1);
    check("basic_data", suc_claps_data, 3);
    check("basic_busy_fall", busy, 0);
    check("basic_drop", drop_pulse, 0);
    step(1'b0, 1'b0);
    check("basic_consumed", suc_claps_valid, 0);

    // Refractory: second clap before next tick is accepted but not counted
    step(1'b1, 1'b0);
    check("refr_ready1", clap_ready, 1);
    step(1'b1, 1'b0);
    check("refr_ready2", clap_ready, 1);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1);
      check("refr_no_result", suc_claps_valid, 0);
    end
    step(1'b0, 1'b1);
    check("refr_valid", suc_claps_valid, 1);
    check("refr_data", suc_claps_data, 1);
    step(1'b0, 1'b0);

    // Saturation: 9 claps two frames apart
    for (int f = 0; f <= 18; f++) frame(f % 2 == 0 && f <= 16);
    check("sat_no_early", suc_claps_valid, 0);
    frame(1'b0);
    check("sat_valid", suc_claps_valid, 1);
    check("sat_data", suc_claps_data, 7);
    step(1'b0, 1'b0);

    // Clap on the closing tick keeps the burst open
    step(1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1);
    step(1'b1, 1'b1);
    check("cbc_no_result", suc_claps_valid, 0);
    check("cbc_busy", busy, 1);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1);
      check("cbc_silent", suc_claps_valid, 0);
    end
    step(1'b0, 1'b1);
    check("cbc_valid", suc_claps_valid, 1);
    check("cbc_data", suc_claps_data, 2);
    step(1'b0, 1'b0);
    check("cbc_consumed", suc_claps_valid, 0);

    // Back-pressure: second result dropped while the first is held
    suc_claps_ready = 1'b0;
    frame(1'b1);
    for (int i = 0; i < 3; i++) frame(1'b0);
    check("bp_valid1", suc_claps_valid, 1);
    check("bp_data1", suc_claps_data, 1);
    frame(1'b1);
    for (int i = 0; i < 2; i++) begin
      frame(1'b0);
      check("bp_hold_data", suc_claps_data, 1);
      check("bp_no_drop", drop_pulse, 0);
    end
    frame(1'b0);
    check("bp_drop", drop_pulse, 1);
    check("bp_data_after_drop", suc_claps_data, 1);
    check("bp_busy", busy, 0);
    step(1'b0, 1'b0);
    check("bp_drop_once", drop_pulse, 0);
    check("bp_still_valid", suc_claps_valid, 1);
    suc_claps_ready = 1'b1;
    check("bp_data_at_ready", suc_claps_data, 1);
    step(1'b0, 1'b0);
    check("bp_consumed", suc_claps_valid, 0);

    // EMIT_ZERO: fresh reset, then two zero reports over 8 silent ticks
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    step(1'b0, 1'b0);
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 3; i++) begin
        step(1'b0, 1'b1);
        check("ez_silent", valid_z, 0);
        check("ez_base_quiet", suc_claps_valid, 0);
      end
      step(1'b0, 1'b1);
      check("ez_valid", valid_z, 1);
      check("ez_data", data_z, 0);
      check("ez_busy", busy_z, 0);
    end

    // Reset mid-burst with a pending result on the base instance
    suc_claps_ready = 1'b0;
    frame(1'b1);
    for (int i = 0; i < 3; i++) frame(1'b0);
    check("mr_pending", suc_claps_valid, 1);
    step(1'b1, 1'b0);
    step(1'b0, 1'b1);
    step(1'b1, 1'b0);
    check("mr_busy", busy, 1);
    check("mr_busy_z", busy_z, 1);
    #2;
    reset = 1'b1;
    #1;
    check("mr_valid_clr", suc_claps_valid, 0);
    check("mr_data_clr", suc_claps_data, 0);
    check("mr_busy_clr", busy, 0);
    check("mr_busy_z_clr", busy_z, 0);
    check("mr_clap_ready_clr", clap_ready, 0);
    #1;
    reset = 1'b0;
    suc_claps_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 1'b1);
      check("mr_no_result", suc_claps_valid, 0);
      check("mr_no_drop", drop_pulse, 0);
    end
    check("mr_clap_ready_back", clap_ready, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
